// File: rtl/event_if.sv
// event_if: trigger capture, req/ack delivery and status signals of the event responder
interface event_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int SEQ_W  = 8
);
  logic                       trig_i;
  logic [DATA_W-1:0]          data_i;
  logic                       req_o;
  logic [DATA_W-1:0]          data_o;
  logic [SEQ_W-1:0]           seq_o;
  logic                       ack_i;
  logic [$clog2(DEPTH):0]     pending_o;
  logic                       overflow_o;
  logic                       clr_ovf_i;
  modport slave (
    input  trig_i, data_i, ack_i, clr_ovf_i,
    output req_o, data_o, seq_o, pending_o, overflow_o
  );
  modport master (
    output trig_i, data_i, ack_i, clr_ovf_i,
    input  req_o, data_o, seq_o, pending_o, overflow_o
  );
endinterface

// File: rtl/event_responder.sv
// event_responder: stamps trigger pulses, queues them and delivers them over a four-phase req/ack handshake
module event_responder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int SEQ_W  = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  event_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + SEQ_W;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t            state, nxt;
  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic [SEQ_W-1:0]  seq_ctr;
  logic [DATA_W-1:0] data_q;
  logic [SEQ_W-1:0]  seq_q;
  logic              ovf;
  logic              full, pop, push, drop, load;
  // Next state and FIFO control; a pop at the same edge frees a slot for a trigger on a full FIFO
  always_comb begin
    nxt  = state;
    full = cnt == CW'(DEPTH);
    pop  = state == REQ && bus.ack_i;
    push = bus.trig_i && (!full || pop);
    drop = bus.trig_i && full && !pop;
    nxt  = state == IDLE ? (cnt != '0 ? REQ : IDLE) :
           state == REQ  ? (bus.ack_i ? WAIT : REQ) :
                           (bus.ack_i ? WAIT : IDLE);
    load = nxt == REQ && state != REQ;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  // Event storage; emptiness is tracked by the pointers, so the array itself needs no reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.data_i, seq_ctr};
  // Pointers, occupancy, sequence counter and sticky overflow (a new drop beats a clear)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      seq_ctr <= '0;
      ovf     <= 1'b0;
    end else begin
      wr_ptr  <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr  <= pop ? rd_ptr + AW'(1) : rd_ptr;
      cnt     <= cnt + CW'(push) - CW'(pop);
      seq_ctr <= bus.trig_i ? seq_ctr + SEQ_W'(1) : seq_ctr;
      ovf     <= drop ? 1'b1 : bus.clr_ovf_i ? 1'b0 : ovf;
    end
  // Head entry is latched on entry to REQ so it cannot move while req_o is high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q <= '0;
      seq_q  <= '0;
    end else if (load) begin
      {data_q, seq_q} <= mem[rd_ptr];
    end
  assign bus.req_o      = state == REQ;
  assign bus.data_o     = data_q;
  assign bus.seq_o      = seq_q;
  assign bus.pending_o  = cnt;
  assign bus.overflow_o = ovf;
endmodule

// File: tb/tb_event_responder.sv
// tb_event_responder: table-driven directed check of event_responder
module tb_event_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  event_if #(.DATA_W(8), .DEPTH(4), .SEQ_W(8)) bus ();
  event_responder #(.DATA_W(8), .DEPTH(4), .SEQ_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  typedef struct {
    logic       rst, trig;
    logic [7:0] d;
    logic       ack, clr;
    logic       req;
    logic [7:0] dat, sq;
    int         pend;
    logic       ovf;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic rst, trig, input logic [7:0] d, input logic ack, clr,
                     input logic req, input logic [7:0] dat, sq, input int pend, input logic ovf);
    vec_t v;
    v.rst = rst; v.trig = trig; v.d = d; v.ack = ack; v.clr = clr;
    v.req = req; v.dat = dat; v.sq = sq; v.pend = pend; v.ovf = ovf;
    tbl.push_back(v);
  endtask
  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int idx, input logic req, input logic [7:0] dat, sq,
                         input int pend, input logic ovf);
    chk({tag, ".req"}, idx, int'(bus.req_o), int'(req));
    chk({tag, ".data"}, idx, int'(bus.data_o), int'(dat));
    chk({tag, ".seq"}, idx, int'(bus.seq_o), int'(sq));
    chk({tag, ".pend"}, idx, int'(bus.pending_o), pend);
    chk({tag, ".ovf"}, idx, int'(bus.overflow_o), int'(ovf));
  endtask
  initial begin
    //   rst trig d      ack clr | req dat    seq   pend ovf
    add(0, 1, 8'h5A, 0, 0,  0, 8'h00, 8'h00, 1, 0);
    add(0, 0, 8'h00, 0, 0,  1, 8'h5A, 8'h00, 1, 0);
    add(0, 0, 8'h00, 0, 0,  1, 8'h5A, 8'h00, 1, 0);
    add(0, 0, 8'h00, 1, 0,  0, 8'h5A, 8'h00, 0, 0);
    add(0, 0, 8'h00, 0, 0,  0, 8'h5A, 8'h00, 0, 0);
    add(1, 0, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0);
    add(0, 1, 8'h01, 0, 0,  0, 8'h00, 8'h00, 1, 0);
    add(0, 1, 8'h02, 0, 0,  1, 8'h01, 8'h00, 2, 0);
    add(0, 1, 8'h03, 0, 0,  1, 8'h01, 8'h00, 3, 0);
    add(0, 1, 8'h04, 0, 0,  1, 8'h01, 8'h00, 4, 0);
    add(0, 1, 8'h05, 0, 0,  1, 8'h01, 8'h00, 4, 1);
    add(0, 0, 8'h00, 1, 0,  0, 8'h01, 8'h00, 3, 1);
    add(0, 0, 8'h00, 0, 0,  0, 8'h01, 8'h00, 3, 1);
    add(0, 0, 8'h00, 0, 0,  1, 8'h02, 8'h01, 3, 1);
    add(0, 0, 8'h00, 1, 0,  0, 8'h02, 8'h01, 2, 1);
    add(0, 0, 8'h00, 0, 0,  0, 8'h02, 8'h01, 2, 1);
    add(0, 0, 8'h00, 0, 0,  1, 8'h03, 8'h02, 2, 1);
    add(0, 0, 8'h00, 1, 0,  0, 8'h03, 8'h02, 1, 1);
    add(0, 0, 8'h00, 0, 0,  0, 8'h03, 8'h02, 1, 1);
    add(0, 0, 8'h00, 0, 0,  1, 8'h04, 8'h03, 1, 1);
    add(0, 0, 8'h00, 1, 0,  0, 8'h04, 8'h03, 0, 1);
    add(0, 0, 8'h00, 0, 0,  0, 8'h04, 8'h03, 0, 1);
    add(0, 1, 8'h66, 0, 0,  0, 8'h04, 8'h03, 1, 1);
    add(0, 0, 8'h00, 0, 0,  1, 8'h66, 8'h05, 1, 1);
    add(0, 0, 8'h00, 1, 0,  0, 8'h66, 8'h05, 0, 1);
    add(0, 0, 8'h00, 0, 0,  0, 8'h66, 8'h05, 0, 1);
    add(0, 0, 8'h00, 0, 1,  0, 8'h66, 8'h05, 0, 0);
    add(0, 1, 8'hA0, 0, 0,  0, 8'h66, 8'h05, 1, 0);
    add(0, 1, 8'hA1, 0, 0,  1, 8'hA0, 8'h06, 2, 0);
    add(0, 1, 8'hA2, 0, 0,  1, 8'hA0, 8'h06, 3, 0);
    add(0, 1, 8'hA3, 0, 0,  1, 8'hA0, 8'h06, 4, 0);
    add(0, 1, 8'hA4, 1, 0,  0, 8'hA0, 8'h06, 4, 0);
    add(0, 0, 8'h00, 0, 0,  0, 8'hA0, 8'h06, 4, 0);
    add(0, 1, 8'hB0, 0, 1,  1, 8'hA1, 8'h07, 4, 1);
    add(0, 0, 8'h00, 0, 1,  1, 8'hA1, 8'h07, 4, 0);
    add(0, 0, 8'h00, 1, 0,  0, 8'hA1, 8'h07, 3, 0);
    add(0, 0, 8'h00, 0, 0,  0, 8'hA1, 8'h07, 3, 0);
    add(0, 0, 8'h00, 0, 0,  1, 8'hA2, 8'h08, 3, 0);
    add(0, 0, 8'h00, 1, 0,  0, 8'hA2, 8'h08, 2, 0);
    add(0, 0, 8'h00, 0, 0,  0, 8'hA2, 8'h08, 2, 0);
    add(0, 0, 8'h00, 0, 0,  1, 8'hA3, 8'h09, 2, 0);
    add(0, 0, 8'h00, 1, 0,  0, 8'hA3, 8'h09, 1, 0);
    add(0, 0, 8'h00, 0, 0,  0, 8'hA3, 8'h09, 1, 0);
    add(0, 0, 8'h00, 0, 0,  1, 8'hA4, 8'h0A, 1, 0);
    add(0, 0, 8'h00, 1, 0,  0, 8'hA4, 8'h0A, 0, 0);
    add(0, 0, 8'h00, 0, 0,  0, 8'hA4, 8'h0A, 0, 0);
    add(0, 1, 8'hAA, 0, 0,  0, 8'hA4, 8'h0A, 1, 0);
    add(0, 0, 8'h00, 0, 0,  1, 8'hAA, 8'h0C, 1, 0);
    add(0, 1, 8'h11, 0, 0,  1, 8'hAA, 8'h0C, 2, 0);
    add(0, 0, 8'h00, 0, 0,  1, 8'hAA, 8'h0C, 2, 0);
    add(0, 0, 8'h00, 1, 0,  0, 8'hAA, 8'h0C, 1, 0);
    add(0, 0, 8'h00, 0, 0,  0, 8'hAA, 8'h0C, 1, 0);
    add(0, 0, 8'h00, 0, 0,  1, 8'h11, 8'h0D, 1, 0);
    add(0, 1, 8'h21, 0, 0,  1, 8'h11, 8'h0D, 2, 0);
    add(0, 1, 8'h22, 0, 0,  1, 8'h11, 8'h0D, 3, 0);
    bus.trig_i = 1'b0; bus.data_i = '0; bus.ack_i = 1'b0; bus.clr_ovf_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", -1, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      rst_n         = ~tbl[i].rst;
      bus.trig_i    = tbl[i].trig;
      bus.data_i    = tbl[i].d;
      bus.ack_i     = tbl[i].ack;
      bus.clr_ovf_i = tbl[i].clr;
      @(posedge clk);
      #1;
      chk_all("vec", i, tbl[i].req, tbl[i].dat, tbl[i].sq, tbl[i].pend, tbl[i].ovf);
    end
    bus.trig_i = 1'b0; bus.data_i = '0; bus.ack_i = 1'b0; bus.clr_ovf_i = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.trig_i = 1'b1;
    bus.data_i = 8'h77;
    @(posedge clk);
    #1;
    bus.trig_i = 1'b0;
    bus.data_i = '0;
    chk_all("post_rst", 1, 1'b0, 8'h00, 8'h00, 1, 1'b0);
    @(posedge clk);
    #1;
    chk_all("post_rst", 2, 1'b1, 8'h77, 8'h00, 1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/event_responder.md
# event_responder

Responding end of the design's event-trigger path. Captures single-cycle trigger pulses from an initiator, stamping each with a data sample and a sequence number. Queues them in a small FIFO and delivers them one at a time to a downstream consumer over a four-phase req/ack handshake. Reports queue occupancy and a sticky overflow flag for dropped triggers.

## Interface
- DATA_W, 8, width of the data sample captured with each trigger
- DEPTH, 4, event FIFO depth; power of two, ≥2
- SEQ_W, 8, width of the sequence counter
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- trig_i  input  1  event trigger; each high cycle is one event
- data_i  input  DATA_W  sample captured on a trigger cycle
- req_o  output  1  event valid / request to consumer (registered)
- data_o  output  DATA_W  head-entry data; stable while req_o=1
- seq_o  output  SEQ_W  head-entry sequence number; stable while req_o=1
- ack_i  input  1  consumer acknowledge (four-phase)
- pending_o  output  $clog2(DEPTH)+1  entries held in the FIFO, including the one being presented
- overflow_o  output  1  sticky: a trigger was dropped
- clr_ovf_i  input  1  clears overflow_o

## Operation
- Capture: at an edge with trig_i=1, {data_i, seq} is written to the FIFO tail if a slot is free.
  - seq increments by 1 mod 2^SEQ_W on every trigger, accepted or dropped, so gaps in seq_o expose losses.
  - The first trigger after reset carries seq 0.
- Full: a trigger at an edge where the FIFO is full and no pop occurs is dropped; overflow_o sets.
  - If a pop occurs at the same edge, the freed slot is used and the trigger is accepted.
- Overflow clear: clr_ovf_i=1 clears overflow_o. If a new drop occurs at the same edge, set wins.
- FSM states:
  - IDLE: req_o=0. Moves to REQ when the FIFO is non-empty.
  - REQ: req_o=1, data_o/seq_o = head entry. On ack_i=1: pop head, go to WAIT.
  - WAIT: req_o=0. When ack_i=0, go to IDLE.
- ack_i in IDLE is ignored. ack_i=0 in REQ holds indefinitely with no timeout.
- data_o/seq_o do not change while req_o=1, regardless of concurrent pushes.
- Pointers: DEPTH-entry circular buffer, wrap-around modulo DEPTH. pending_o = push count − pop count, range 0..DEPTH.
- Reset (asserted at any time, including mid-handshake) forces immediately:
  - req_o=0, data_o=0, seq_o=0, pending_o=0, overflow_o=0
  - FSM to IDLE, FIFO emptied, seq counter 0
  - A handshake in flight is abandoned; the consumer must tolerate req_o falling without ack.

## Timing
- Trigger at edge T into an empty FIFO with FSM in IDLE:
  - pending_o=1 after T.
  - req_o=1 with the entry presented after edge T+1. Latency is one cycle.
- ack_i seen high at edge A in REQ: req_o=0 and pending_o decremented after A.
- Earliest next req_o is after edge A+2, with ack_i low at A+1.
- Minimum handshake period: 3 cycles per event with a zero-latency consumer.
- Push and pop at the same edge: pending_o unchanged, both operations take effect.
- overflow_o updates after the edge of the dropped trigger.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then one trigger with data_i=0x5A; consumer acks 2 cycles after req_o:
  - req_o rises 1 cycle after capture, data_o=0x5A, seq_o=0.
  - req_o falls after ack; pending_o returns 0.
- 4 back-to-back triggers (data 1,2,3,4) with ack held low:
  - pending_o=4, overflow_o=0.
  - 5th trigger: overflow_o=1, pending_o=4.
  - Draining yields seq 0,1,2,3.
  - Next trigger carries seq 5.
- FIFO full with a trigger at the same edge as the ack pop: trigger accepted, overflow_o stays 0, pending_o stays 4.
- Push data_i=0x11 while the head (0xAA) is being presented: data_o holds 0xAA until the ack handshake completes, then presents 0x11.
- clr_ovf_i and a dropped trigger at the same edge: overflow_o=1. clr_ovf_i alone on a later edge: overflow_o=0.
- rst_n pulsed low while req_o=1 with 3 entries pending: all outputs 0 immediately; after release, the next trigger carries seq 0.
